spi_slave_xfer_ctrl: RTL and testbench
======================================

# spi_slave_xfer_ctrl

Synthesizable SPI slave transfer controller that sequences the serial datapath on the slave side: it oversamples `sclk`/`cs`/`mosi0` in the system clock domain and sends/receives words for all four CPOL/CPHA modes, MSB- or LSB-first. It sits between the SPI pins and a parallel host port, and exchanges words over valid/ready handshakes. Its bit ordering and edge selection are the reference behaviour that the slave monitor BFM checks against.

## Interface
- `DATA_WIDTH`, 8: bits per SPI word; legal range 2–32.
- `IDLE_WORD`, all-ones: pattern shifted out on `miso0` when no TX word is available (underflow).
- `pclk` input 1: system clock. Every flop is clocked on its rising edge.
- `presetn` input 1: reset, synchronous, active-low.
- `cfg_cpol` input 1: clock polarity; sampled at frame start.
- `cfg_cpha` input 1: clock phase; sampled at frame start.
- `cfg_lsb_first` input 1: 1 = LSB shifted first; sampled at frame start.
- `sclk` input 1: SPI clock, asynchronous.
- `cs` input 1: chip select, active-low, asynchronous.
- `mosi0` input 1: serial data in, asynchronous.
- `miso0` output 1: serial data out. Reset value 1.
- `tx_data` input DATA_WIDTH: next word to transmit.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: controller accepts `tx_data` this cycle. Reset value 0.
- `rx_data` output DATA_WIDTH: received word. Reset value 0.
- `rx_valid` output 1: `rx_data` is valid; held until accepted. Reset value 0.
- `rx_ready` input 1: host accepts `rx_data`.
- `busy` output 1: a frame is in progress. Reset value 0.
- `underflow` output 1: one-cycle pulse. Reset value 0.
- `overrun` output 1: one-cycle pulse. Reset value 0.
- `frame_err` output 1: one-cycle pulse. Reset value 0.

## Operation
- Input sync: `sclk`, `cs` and `mosi0` each pass through a 2-flop synchronizer.
- Edge detect: one further register on synced `sclk` yields `rise` and `fall` pulses.
- Edge naming: the lead edge leaves the `cfg_cpol` idle level; the trail edge returns to it.
- FSM has three states: IDLE, LOAD, SHIFT.
- IDLE → LOAD when synced `cs` falls. On entry, latch the three `cfg_*` bits, clear the bit counter and assert `busy`.
- LOAD lasts one cycle:
  - If `tx_valid`=1, the shift-out register takes `tx_data` and `tx_ready` pulses.
  - Otherwise it takes `IDLE_WORD` and `underflow` pulses.
  - If latched cpha=0, `miso0` is driven with the first bit. Then go to SHIFT.
- SHIFT with cpha=0: sample `mosi0` on lead, shift `miso0` on trail.
- SHIFT with cpha=1: shift `miso0` on lead (the first lead drives bit 0), sample on trail.
- First bit is the MSB (`DATA_WIDTH`-1) when `lsb_first`=0, bit 0 when `lsb_first`=1. Shift direction follows.
- Bit counter is `$clog2(DATA_WIDTH)`+1 bits and counts samples.
- At sample number `DATA_WIDTH`:
  - Assembled word goes to the RX holding register and `rx_valid` is set; the counter wraps to 0.
  - The next TX word is fetched, with the same `tx_valid`/underflow rule as LOAD.
  - cpha=0: the fetched word's first bit is driven on the following trail edge.
  - cpha=1: it is driven on the next lead edge.
- Consecutive words in one `cs` frame are back-to-back; no gap is required.
- RX buffer is 1 deep. If `rx_valid`=1 and `rx_ready`=0 when a new word completes:
  - The new word overwrites `rx_data` and `overrun` pulses.
  - If `rx_ready`=1 in that same cycle, the old word counts as consumed and there is no overrun.
- `rx_valid` clears on the cycle after `rx_valid`&&`rx_ready`, unless a new word completes in that cycle.
- SHIFT → IDLE when synced `cs` rises:
  - If the counter ≠ 0, pulse `frame_err` and discard the partial RX word. The unsent TX remainder is dropped.
  - `busy` drops and `miso0` returns to 1.
- Changes to `cfg_*` during a frame have no effect until the next `cs` fall.
- Reset: FSM goes to IDLE, all outputs take their reset values and the synchronizers clear to `cs`=1, `sclk`=0. Reset mid-frame abandons the frame with no `frame_err`.

## Timing
- Pin-to-decision latency is 3 `pclk` cycles: 2 sync stages plus edge detect.
- `miso0` changes 4 `pclk` cycles after the shifting `sclk` edge. It is registered.
- Requirement: each `sclk` half-period ≥ 4 `pclk` periods. `cs` fall to first lead edge ≥ 4 `pclk` periods (covers LOAD for cpha=0).
- `rx_valid` asserts 4 `pclk` cycles after the final sampling edge of a word.
- `tx_ready` is only ever a one-cycle pulse: in LOAD, or in the cycle a word completes.
- `rise` and `fall` never occur together. A `cs` rise in the same cycle as an edge takes priority; that edge is ignored.

## Test plan
- Mode 0, MSB first, `DATA_WIDTH`=8: master sends 0xA5 while `tx_data`=0x3C. Expect `rx_data`=0xA5, and `miso0` carries 0,0,1,1,1,1,0,0 on the falling-edge shifts.
- Mode 3, LSB first: master sends 0x01. Expect `rx_data`=0x01. `miso0` must carry `tx_data`=0x80 as 0,...,0,1.
- Modes 1 and 2: three back-to-back words 0x11, 0x22, 0x33 in one `cs` frame. Expect three `rx_valid` handshakes in order, and `tx_ready` pulsed 3 times.
- `tx_valid`=0 at frame start → `underflow` pulse and `miso0` outputs 0xFF. `rx_ready` held 0 across 2 words → one `overrun` pulse and `rx_data` = the second word.
- `cs` rises after 5 bits → `frame_err` pulse, no `rx_valid`, `busy`=0 within 3 `pclk` cycles.
- `presetn` low mid-word, then a new full frame → no `frame_err`; the new word is received correctly.

Source files
------------

// File: rtl/spi_slave_xfer_ctrl.sv
// SPI slave transfer controller: oversamples the SPI pins in the pclk domain and
// moves DATA_WIDTH-bit words between the serial lines and a parallel host port.
module spi_slave_xfer_ctrl #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = '1
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  cfg_cpol,
  input  logic                  cfg_cpha,
  input  logic                  cfg_lsb_first,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi0,
  output logic                  miso0,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  busy,
  output logic                  underflow,
  output logic                  overrun,
  output logic                  frame_err
);

  // Host handshakes: a word moves on tx and rx only in a cycle where valid and
  // ready are both high; valid never waits for ready and rx_valid holds until taken.

  localparam int unsigned     CW       = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic                   cs_s1_q, cs_s2_q, cs_s3_q;
  logic                   mosi_s1_q, mosi_s2_q;
  logic                   cpol_q, cpol_d;
  logic                   cpha_q, cpha_d;
  logic                   lsb_q, lsb_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  sin_q, sin_d;
  logic [DATA_WIDTH-1:0]  sout_q, sout_d;
  logic                   out_bit_q, out_bit_d;
  logic                   miso_q, miso_d;
  logic                   done_q, done_d;
  logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   busy_q, busy_d;
  logic                   underflow_q, underflow_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_err_q, frame_err_d;

  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic                   lead, trail, sample_ev, drive_ev, fetch;
  logic [DATA_WIDTH-1:0]  tx_word;

  function automatic logic head_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w,
                                                      input logic lsb);
    return lsb ? {1'b1, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], 1'b1};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                     input logic lsb, input logic b);
    return lsb ? {b, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], b};
  endfunction

  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
  assign cs_rise   = cs_s2_q & ~cs_s3_q;
  assign cs_fall   = ~cs_s2_q & cs_s3_q;

  // Lead leaves the idle level chosen by cpol; a cs rise masks any edge in its cycle.
  assign lead      = cpol_q ? sclk_fall : sclk_rise;
  assign trail     = cpol_q ? sclk_rise : sclk_fall;
  assign sample_ev = (state_q == ST_SHIFT) && !cs_rise && (cpha_q ? trail : lead);
  assign drive_ev  = (state_q == ST_SHIFT) && !cs_rise && (cpha_q ? lead : trail);

  assign fetch     = !cs_rise && ((state_q == ST_LOAD) || ((state_q == ST_SHIFT) && done_q));
  assign tx_word   = tx_valid ? tx_data : IDLE_WORD;
  assign tx_ready  = fetch && tx_valid;

  always_comb begin
    state_d     = state_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    lsb_d       = lsb_q;
    cnt_d       = cnt_q;
    sin_d       = sin_q;
    sout_d      = sout_q;
    out_bit_d   = out_bit_q;
    miso_d      = (state_q == ST_SHIFT) ? out_bit_q : 1'b1;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    underflow_d = 1'b0;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_LOAD;
          cpol_d    = cfg_cpol;
          cpha_d    = cfg_cpha;
          lsb_d     = cfg_lsb_first;
          cnt_d     = '0;
          sin_d     = '0;
          out_bit_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      ST_LOAD: begin
        if (cs_rise) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          out_bit_d = 1'b1;
        end else begin
          state_d     = ST_SHIFT;
          sout_d      = tx_word;
          underflow_d = ~tx_valid;
          // cpha=0 masters sample on the first lead, so bit 0 must already be out.
          if (!cpha_q) begin
            out_bit_d = head_bit(tx_word, lsb_q);
            miso_d    = head_bit(tx_word, lsb_q);
            sout_d    = shift_out(tx_word, lsb_q);
          end
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          out_bit_d   = 1'b1;
          miso_d      = 1'b1;
          frame_err_d = (cnt_q != '0);
          cnt_d       = '0;
        end else begin
          if (sample_ev) begin
            sin_d = shift_in(sin_q, lsb_q, mosi_s2_q);
            if (cnt_q == LAST_CNT) begin
              cnt_d  = '0;
              done_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          if (drive_ev) begin
            out_bit_d = head_bit(sout_q, lsb_q);
            sout_d    = shift_out(sout_q, lsb_q);
          end
          // The fetched word is left unshifted; its first bit goes out on the next drive edge.
          if (done_q) begin
            sout_d      = tx_word;
            underflow_d = ~tx_valid;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (done_q) begin
      rx_data_d  = sin_q;
      rx_valid_d = 1'b1;
      overrun_d  = rx_valid_q && !rx_ready;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q     <= ST_IDLE;
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_s3_q   <= 1'b0;
      cs_s1_q     <= 1'b1;
      cs_s2_q     <= 1'b1;
      cs_s3_q     <= 1'b1;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsb_q       <= 1'b0;
      cnt_q       <= '0;
      sin_q       <= '0;
      sout_q      <= '1;
      out_bit_q   <= 1'b1;
      miso_q      <= 1'b1;
      done_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      underflow_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_s1_q   <= sclk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_s3_q   <= sclk_s2_q;
      cs_s1_q     <= cs;
      cs_s2_q     <= cs_s1_q;
      cs_s3_q     <= cs_s2_q;
      mosi_s1_q   <= mosi0;
      mosi_s2_q   <= mosi_s1_q;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      lsb_q       <= lsb_d;
      cnt_q       <= cnt_d;
      sin_q       <= sin_d;
      sout_q      <= sout_d;
      out_bit_q   <= out_bit_d;
      miso_q      <= miso_d;
      done_q      <= done_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
      underflow_q <= underflow_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign miso0     = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = busy_q;
  assign underflow = underflow_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_xfer_ctrl.sv
// Directed bench for spi_slave_xfer_ctrl: a pin-level SPI master drives known words,
// received words go through an expected queue and the shifted-out bits are compared.
module tb_spi_slave_xfer_ctrl;

  localparam int H = 8;  // sclk half-period in pclk cycles

  logic       pclk = 1'b0;
  logic       presetn;
  logic       cfg_cpol, cfg_cpha, cfg_lsb_first;
  logic       sclk, cs, mosi0;
  logic       miso0;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       busy, underflow, overrun, frame_err;

  logic [7:0] tx_words [0:15];
  logic [3:0] tx_idx, tx_cnt;
  logic       tx_en;
  logic [7:0] m_words [0:7];
  logic [7:0] cap_words [0:7];
  logic       cur_lsb;
  logic [7:0] exp_q[$];

  int n_tests = 0, n_fail = 0;
  int n_tx = 0, n_unf = 0, n_ovr = 0, n_ferr = 0, n_rx = 0;

  assign tx_data  = tx_words[tx_idx];
  assign tx_valid = tx_en && (tx_idx < tx_cnt);

  spi_slave_xfer_ctrl #(.DATA_WIDTH(8)) dut (
    .pclk(pclk), .presetn(presetn),
    .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_lsb_first(cfg_lsb_first),
    .sclk(sclk), .cs(cs), .mosi0(mosi0), .miso0(miso0),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .underflow(underflow), .overrun(overrun), .frame_err(frame_err)
  );

  // clock / reset
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard / pulse monitor
  always @(negedge pclk) begin
    if (presetn) begin
      if (rx_valid && rx_ready) begin
        n_rx++;
        if (exp_q.size() == 0) chk("rx_unexpected", 32'd1, 32'd0);
        else chk("rx_word", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
      if (tx_valid && tx_ready) n_tx++;
      if (underflow) n_unf++;
      if (overrun)   n_ovr++;
      if (frame_err) n_ferr++;
    end
  end

  // tx source advances right after the edge that takes the word
  always begin
    @(negedge pclk);
    if (tx_valid && tx_ready) begin
      @(posedge pclk);
      #1 tx_idx = tx_idx + 4'd1;
    end
  end

  function automatic logic mbit(input int i);
    logic [7:0] w;
    int b;
    w = m_words[3'(i / 8)];
    b = i % 8;
    return cur_lsb ? w[3'(b)] : w[3'(7 - b)];
  endfunction

  task automatic capture(input int i);
    int b;
    b = i % 8;
    cap_words[3'(i / 8)][3'(cur_lsb ? b : 7 - b)] = miso0;
  endtask

  task automatic set_tx(input logic [7:0] w0, w1, w2, input logic [3:0] n, input logic en);
    tx_words[0] = w0;
    tx_words[1] = w1;
    tx_words[2] = w2;
    tx_cnt      = n;
    tx_idx      = 4'd0;
    tx_en       = en;
  endtask

  task automatic clear_counts();
    @(posedge pclk);
    #1;
    n_tx = 0; n_unf = 0; n_ovr = 0; n_ferr = 0; n_rx = 0;
  endtask

  // SPI master driver; stops after nbits and optionally leaves cs low
  task automatic xfer(input logic cpol, cpha, lsb, input int nbits, input logic end_frame);
    @(negedge pclk);
    cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb_first = lsb; cur_lsb = lsb;
    sclk = cpol;
    for (int i = 0; i < 8; i++) cap_words[i] = 8'h00;
    repeat (6) @(negedge pclk);
    cs = 1'b0;
    if (!cpha) mosi0 = mbit(0);
    repeat (H) @(negedge pclk);
    for (int i = 0; i < nbits; i++) begin
      if (cpha) mosi0 = mbit(i);
      else capture(i);
      sclk = ~cpol;
      repeat (H) @(negedge pclk);
      if (cpha) capture(i);
      else mosi0 = mbit(i + 1);
      sclk = cpol;
      repeat (H) @(negedge pclk);
    end
    if (end_frame) begin
      cs = 1'b1;
      repeat (H) @(negedge pclk);
    end
  endtask

  initial begin
    presetn = 1'b0; cs = 1'b1; sclk = 1'b0; mosi0 = 1'b0; rx_ready = 1'b1;
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0; cur_lsb = 1'b0;
    for (int i = 0; i < 16; i++) tx_words[i] = 8'h00;
    for (int i = 0; i < 8; i++) m_words[i] = 8'h00;
    set_tx(8'h00, 8'h00, 8'h00, 4'd0, 1'b0);

    repeat (4) @(negedge pclk);
    chk("rst_miso",     {31'd0, miso0},     32'd1);
    chk("rst_tx_ready", {31'd0, tx_ready},  32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid},  32'd0);
    chk("rst_rx_data",  {24'd0, rx_data},   32'd0);
    chk("rst_busy",     {31'd0, busy},      32'd0);
    chk("rst_underflow",{31'd0, underflow}, 32'd0);
    chk("rst_overrun",  {31'd0, overrun},   32'd0);
    chk("rst_frame_err",{31'd0, frame_err}, 32'd0);
    presetn = 1'b1;
    repeat (4) @(negedge pclk);

    // mode 0, MSB first
    set_tx(8'h3C, 8'h00, 8'h00, 4'd1, 1'b1);
    m_words[0] = 8'hA5; exp_q.push_back(8'hA5);
    clear_counts();
    xfer(1'b0, 1'b0, 1'b0, 8, 1'b1);
    chk("m0_miso_word", {24'd0, cap_words[0]}, 32'h3C);
    chk("m0_tx_count",  n_tx, 32'd1);
    chk("m0_rx_count",  n_rx, 32'd1);
    chk("m0_busy_end",  {31'd0, busy}, 32'd0);
    chk("m0_miso_idle", {31'd0, miso0}, 32'd1);

    // mode 3, LSB first
    set_tx(8'h80, 8'h00, 8'h00, 4'd1, 1'b1);
    m_words[0] = 8'h01; exp_q.push_back(8'h01);
    clear_counts();
    xfer(1'b1, 1'b1, 1'b1, 8, 1'b1);
    chk("m3_miso_word", {24'd0, cap_words[0]}, 32'h80);
    chk("m3_rx_count",  n_rx, 32'd1);

    // mode 1, MSB first, three back-to-back words
    set_tx(8'hC1, 8'hC2, 8'hC3, 4'd3, 1'b1);
    m_words[0] = 8'h11; m_words[1] = 8'h22; m_words[2] = 8'h33;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    clear_counts();
    xfer(1'b0, 1'b1, 1'b0, 24, 1'b1);
    chk("m1_miso_w0", {24'd0, cap_words[0]}, 32'hC1);
    chk("m1_miso_w1", {24'd0, cap_words[1]}, 32'hC2);
    chk("m1_miso_w2", {24'd0, cap_words[2]}, 32'hC3);
    chk("m1_tx_count", n_tx, 32'd3);
    chk("m1_rx_count", n_rx, 32'd3);

    // mode 2, LSB first, three back-to-back words
    set_tx(8'hD1, 8'hD2, 8'hD3, 4'd3, 1'b1);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    clear_counts();
    xfer(1'b1, 1'b0, 1'b1, 24, 1'b1);
    chk("m2_miso_w0", {24'd0, cap_words[0]}, 32'hD1);
    chk("m2_miso_w1", {24'd0, cap_words[1]}, 32'hD2);
    chk("m2_miso_w2", {24'd0, cap_words[2]}, 32'hD3);
    chk("m2_tx_count", n_tx, 32'd3);
    chk("m2_rx_count", n_rx, 32'd3);

    // underflow: no tx word at frame start nor at word end
    set_tx(8'h00, 8'h00, 8'h00, 4'd0, 1'b0);
    m_words[0] = 8'h5A; exp_q.push_back(8'h5A);
    clear_counts();
    xfer(1'b0, 1'b0, 1'b0, 8, 1'b1);
    chk("unf_miso_word", {24'd0, cap_words[0]}, 32'hFF);
    chk("unf_count",     n_unf, 32'd2);
    chk("unf_tx_count",  n_tx, 32'd0);

    // overrun: host not ready across two words
    @(posedge pclk); #1 rx_ready = 1'b0;
    m_words[0] = 8'h12; m_words[1] = 8'h34;
    clear_counts();
    xfer(1'b0, 1'b0, 1'b0, 16, 1'b1);
    chk("ovr_count",    n_ovr, 32'd1);
    chk("ovr_rx_valid", {31'd0, rx_valid}, 32'd1);
    chk("ovr_rx_data",  {24'd0, rx_data}, 32'h34);
    exp_q.push_back(8'h34);
    @(posedge pclk); #1 rx_ready = 1'b1;
    repeat (3) @(negedge pclk);
    chk("ovr_rx_drained", {31'd0, rx_valid}, 32'd0);
    chk("ovr_rx_count",   n_rx, 32'd1);

    // cs rises after 5 bits
    m_words[0] = 8'h3A;
    clear_counts();
    xfer(1'b0, 1'b0, 1'b0, 5, 1'b0);
    chk("ferr_busy_mid", {31'd0, busy}, 32'd1);
    cs = 1'b1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("ferr_busy_drop", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge pclk);
    chk("ferr_count",    n_ferr, 32'd1);
    chk("ferr_rx_count", n_rx, 32'd0);
    chk("ferr_rx_valid", {31'd0, rx_valid}, 32'd0);

    // reset mid-word, then a full frame
    m_words[0] = 8'h77;
    clear_counts();
    xfer(1'b0, 1'b0, 1'b0, 3, 1'b0);
    chk("rstmid_busy", {31'd0, busy}, 32'd1);
    presetn = 1'b0; cs = 1'b1; sclk = 1'b0; mosi0 = 1'b0;
    repeat (3) @(negedge pclk);
    presetn = 1'b1;
    repeat (2) @(negedge pclk);
    chk("rstmid_busy_clr", {31'd0, busy}, 32'd0);
    set_tx(8'h96, 8'h00, 8'h00, 4'd1, 1'b1);
    m_words[0] = 8'hC3; exp_q.push_back(8'hC3);
    xfer(1'b0, 1'b0, 1'b0, 8, 1'b1);
    chk("rstmid_ferr",      n_ferr, 32'd0);
    chk("rstmid_miso_word", {24'd0, cap_words[0]}, 32'h96);
    chk("rstmid_rx_count",  n_rx, 32'd1);

    repeat (4) @(negedge pclk);
    chk("exp_q_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
